// File: rtl/seg_scan_decoder_pkg.sv
// Shared display definitions: active-low 7-segment patterns (g..a) and the
// scan-decoder control states.
package seg_scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index i holds the pattern that displays hex digit i.
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_code_lookup.sv
// Combinational 7-segment pattern to hex nibble decode; flags the all-off
// pattern as blank and anything unrecognised as an error.
module seg_code_lookup
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_err
);

  always_comb begin
    nibble   = '0;
    is_blank = (seg == SEG_BLANK);
    is_err   = !is_blank;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODE[i]) begin
        nibble = 4'(i);
        is_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the displayed hex frame from a multiplexed, active-low 7-segment
// scan bus: synchronize, debounce, decode, and publish complete frames.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [7:0]              seg,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    frame_valid,
  output logic                    code_err,
  output scan_state_e             state_dbg
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0] sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  scan_state_e   state_q, state_d;

  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d, value_q;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, dp_q;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, blank_q;
  logic                    frame_valid_q, code_err_q;

  logic                  changed, stable_hit, accept;
  logic [NUM_DIGITS-1:0] s_an, an_act;
  logic [7:0]            s_seg;
  logic                  one_hot;
  logic [IW-1:0]         idx;
  logic [3:0]            nibble;
  logic                  is_blank, is_err;
  logic                  write_en, err_hit, frame_copy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {an, seg};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign changed    = (sync2_q != prev_q);
  assign stable_hit = !changed && (cnt_q == CW'(STABLE_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (changed)                         cnt_d = '0;
    else if (cnt_q != CW'(STABLE_CYCLES)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (changed) state_d = ST_SETTLE;
      ST_SETTLE: if (!changed && stable_hit) state_d = ST_HOLD;
      ST_HOLD:   if (changed) state_d = ST_SETTLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == ST_SETTLE) && stable_hit;
  end

  assign state_dbg = state_q;

  assign s_an    = sync2_q[SW-1:8];
  assign s_seg   = sync2_q[7:0];
  assign an_act  = ~s_an;
  assign one_hot = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_act[i]) idx = IW'(i);
    end
  end

  seg_code_lookup u_lookup (
    .seg      (s_seg[6:0]),
    .nibble   (nibble),
    .is_blank (is_blank),
    .is_err   (is_err)
  );

  assign write_en   = accept && one_hot && !is_err;
  assign err_hit    = accept && one_hot && is_err;
  assign frame_copy = &mask_q;

  // The mask clear for a completed frame is applied before a same-cycle
  // write, so that write counts toward the next frame.
  always_comb begin
    mask_d      = frame_copy ? '0 : mask_q;
    stg_val_d   = stg_val_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    if (write_en) begin
      stg_val_d[idx*4 +: 4] = nibble;
      stg_dp_d[idx]         = ~s_seg[7];
      stg_blank_d[idx]      = is_blank;
      mask_d[idx]           = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q        <= '0;
      stg_val_q     <= '0;
      stg_dp_q      <= '0;
      stg_blank_q   <= '0;
      value_q       <= '0;
      dp_q          <= '0;
      blank_q       <= '1;
      frame_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      mask_q        <= mask_d;
      stg_val_q     <= stg_val_d;
      stg_dp_q      <= stg_dp_d;
      stg_blank_q   <= stg_blank_d;
      frame_valid_q <= frame_copy;
      code_err_q    <= err_hit;
      if (frame_copy) begin
        value_q <= stg_val_q;
        dp_q    <= stg_dp_q;
        blank_q <= stg_blank_q;
      end
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign blank       = blank_q;
  assign frame_valid = frame_valid_q;
  assign code_err    = code_err_q;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digit positions scanned.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required before a digit is accepted.
REQ-003 SHALL have port clk  input  1: single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port an  input  NUM_DIGITS: digit-select lines, active-low, one-hot-low when a digit is driven.
REQ-006 SHALL have port seg  input  8: segment code, active-low; bit7 = dp, bits6..0 = g..a.
REQ-007 SHALL have port value  output  4*NUM_DIGITS: last complete frame; digit i occupies bits 4i+3..4i.
REQ-008 SHALL have port dp  output  NUM_DIGITS: decimal-point state per digit of the last complete frame, 1 = lit.
REQ-009 SHALL have port blank  output  NUM_DIGITS: per-digit blank flag (seg[6:0] all 1) of the last complete frame.
REQ-010 SHALL have port frame_valid  output  1: one-cycle pulse when value/dp/blank update.
REQ-011 SHALL have port code_err  output  1: one-cycle pulse when an accepted sample carries an undecodable pattern.

Function
REQ-012 an and seg SHALL pass through a 2-flop synchronizer before any use; input-to-acceptance latency is 2 + STABLE_CYCLES cycles.
REQ-013 A stability counter SHALL reset to 0 whenever synchronized {an,seg} differs from the previous cycle, else increment, saturating at STABLE_CYCLES.
REQ-014 A sample SHALL be accepted exactly once, in the cycle the counter reaches STABLE_CYCLES; no re-acceptance until {an,seg} changes.
REQ-015 An accepted sample with an not exactly one-hot-low (all 1 or multiple 0) SHALL be ignored with no error.
REQ-016 seg[6:0] decode: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 58->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F (hex).
REQ-017 seg[6:0] = 7F SHALL be stored as blank: nibble 0, blank bit 1, digit counted as received.
REQ-018 Any other seg[6:0] SHALL pulse code_err next cycle, leave staging unchanged, and not mark the digit received.
REQ-019 A decoded digit SHALL be written to staging nibble i, dp bit i = ~seg[7], and received-mask bit i set; a repeated digit overwrites its slot.
REQ-020 When the received mask becomes all ones, the cycle after the final write SHALL copy staging to value/dp/blank, pulse frame_valid for one cycle, and clear the mask.
REQ-021 Acceptance coinciding with the frame-copy cycle SHALL write the new staging entry and set its mask bit after the clear (it counts toward the next frame).
REQ-022 Control SHALL be a 3-state FSM: IDLE (waiting for change), SETTLE (counting), HOLD (accepted, waiting for change); any input change returns to SETTLE.

Reset
REQ-023 While rst_n is low: synchronizers to all ones, counter 0, FSM IDLE, mask 0, staging 0, value 0, dp 0, blank all ones, frame_valid 0, code_err 0.
REQ-024 Reset asserted mid-frame SHALL discard partial staging; the first frame after release requires all NUM_DIGITS digits anew.

Structure
REQ-025 The segment-code constants and the FSM state enum SHALL live in the shared display package also used by the segment encoder.
REQ-026 The combinational pattern-to-nibble lookup SHALL be one sub-module, seg_code_lookup (inputs seg[6:0]; outputs nibble, is_blank, is_err).

Verification
REQ-027 Scan digits 0..7 with codes for 1,2,3,4,5,6,7,8, 10 cycles each -> one frame_valid, value = 32'h87654321, blank = 0.
REQ-028 Digit 3 glitches for 2 cycles, then holds 06 -> no acceptance during glitch; final nibble 3 = E.
REQ-029 Digit 5 driven with seg = FF -> code_err 0, blank[5] = 1, value nibble 5 = 0 after frame.
REQ-030 Digit 2 driven with seg[6:0] = 7E -> code_err pulses once, no frame_valid until digit 2 re-sent valid.
REQ-031 an = 8'b1111_1100 held stable -> ignored, no code_err, mask unchanged.
REQ-032 rst_n low after 5 of 8 digits -> outputs at reset values; 8 fresh digits needed for next frame_valid.
